// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module : mult_pkg
// Brief  : Shared types and constants for the 4-bit shift-add multiplier.
//          Holds the controller state encoding, the multiplier width and the
//          width of the bit index that walks the multiplier register.
// Rev    : 1.0  initial release
// ============================================================================
package mult_pkg;

  localparam int MULT_BITS = 4;
  localparam int IDX_W     = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVAL  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_seq_controller.sv
`default_nettype none
// ============================================================================
// Module : mult_seq_controller
// Brief  : Sequencer for the 4-bit shift-add multiplier datapath. Accepts a
//          start request, loads operands, then performs four add/shift pairs
//          (the add is skipped for zero bits when FIXED_LATENCY=0) and pulses
//          done for one cycle with the product held in the datapath.
// Ports  : clk      - system clock, rising edge
//          reset    - synchronous, active-high
//          start    - operation request, operands valid in the same cycle
//          ready    - high in IDLE and DONE, start accepted only then
//          busy     - high in EVAL, ADD and SHIFT
//          done     - one-cycle pulse, product valid
//          mr0..mr3 - datapath multiplier register bits
//          rsclear  - clear running sum
//          mrld     - load multiplier register
//          mdld     - load multiplicand register
//          rsload   - running sum += multiplicand
//          rsshr    - running sum >>= 1
// Rev    : 1.0  initial release
// ============================================================================
module mult_seq_controller
  import mult_pkg::*;
#(
  parameter bit FIXED_LATENCY = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ready,
  output logic busy,
  output logic done,
  input  logic mr0,
  input  logic mr1,
  input  logic mr2,
  input  logic mr3,
  output logic rsclear,
  output logic mrld,
  output logic mdld,
  output logic rsload,
  output logic rsshr
);

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic [IDX_W-1:0]     idx_inc;
  logic [MULT_BITS-1:0] mr;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MULT_BITS - 1);

  assign mr      = {mr3, mr2, mr1, mr0};
  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    rsclear   = 1'b0;
    mrld      = 1'b0;
    mdld      = 1'b0;
    rsload    = 1'b0;
    rsshr     = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        ready = 1'b1;
        done  = (state == DONE);
        // Loads are Mealy on start so operands only need to be valid in the
        // accept cycle; this also allows a back-to-back start from DONE.
        if (start) begin
          rsclear   = 1'b1;
          mrld      = 1'b1;
          mdld      = 1'b1;
          idx_nxt   = '0;
          state_nxt = EVAL;
        end else begin
          state_nxt = IDLE;
        end
      end
      EVAL: begin
        // Multiplier register is valid from this cycle on; idx is 0 here.
        busy      = 1'b1;
        state_nxt = (FIXED_LATENCY || mr[idx]) ? ADD : SHIFT;
      end
      ADD: begin
        busy      = 1'b1;
        rsload    = mr[idx];
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy  = 1'b1;
        rsshr = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx_inc;
          state_nxt = (FIXED_LATENCY || mr[idx_inc]) ? ADD : SHIFT;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase

    // While reset is held the datapath must see no activity and the status
    // outputs present the reset values, whatever the current state.
    if (reset) begin
      ready   = 1'b1;
      busy    = 1'b0;
      done    = 1'b0;
      rsclear = 1'b0;
      mrld    = 1'b0;
      mdld    = 1'b0;
      rsload  = 1'b0;
      rsshr   = 1'b0;
    end
  end

endmodule : mult_seq_controller
`default_nettype wire
